fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC loaded at reset.
REQ-002 SHALL have parameter HALT_OP, default 6'b111111, which is the opcode that stops fetch.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port nWrite_PC, input, 1 bit: when 1, PC is held.
REQ-006 SHALL have port nWrite_IF_ID, input, 1 bit: when 1, the IF/ID outputs are held.
REQ-007 SHALL have port flush_IF_ID, input, 1 bit: when 1, bubble IF/ID and redirect to j_target.
REQ-008 SHALL have port j_target, input, 32 bits: jump destination, valid while flush_IF_ID=1.
REQ-009 SHALL have port imem_req, output, 1 bit: instruction-memory request.
REQ-010 SHALL have port imem_addr, output, 32 bits: fetch address.
REQ-011 SHALL have port imem_ready, input, 1 bit: imem_rdata valid; completes the request.
REQ-012 SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-013 SHALL have port inst_ID, output, 32 bits: IF/ID instruction (0 = nop).
REQ-014 SHALL have port pc4_ID, output, 32 bits: IF/ID PC+4.
REQ-015 SHALL have port valid_ID, output, 1 bit: IF/ID holds a real instruction.
REQ-016 SHALL have port halted, output, 1 bit: fetch stopped on HALT_OP.

Function
REQ-017 SHALL implement FSM states FETCH (request outstanding), HOLD (word buffered, IF/ID stalled) and HALT.
REQ-018 SHALL drive imem_req=1 in FETCH and 0 in HOLD/HALT, and keep imem_addr=PC stable while imem_req=1.
REQ-019 SHALL, on FETCH with imem_ready=1, nWrite_IF_ID=0 and no pending redirect, load inst_ID=imem_rdata, pc4_ID=PC+4 and valid_ID=1, advance PC to PC+4 when nWrite_PC=0, and stay in FETCH so that back-to-back fetch is possible (1 instruction/cycle when memory is zero-wait).
REQ-020 SHALL, on FETCH with imem_ready=0 and nWrite_IF_ID=0, load a bubble (inst_ID=0, valid_ID=0), leaving PC unchanged.
REQ-021 SHALL, on imem_ready=1 with nWrite_IF_ID=1, capture imem_rdata into a 1-entry hold buffer, hold IF/ID and PC, and go to HOLD.
REQ-022 SHALL, in HOLD with nWrite_IF_ID=0, deliver the buffered word per REQ-019 and return to FETCH.
REQ-023 SHALL, on flush_IF_ID=1 with nWrite_IF_ID=0, load a bubble, set PC=j_target and drop any HOLD buffer.
REQ-024 SHALL, on a flush while a request is outstanding without imem_ready, set a redirect-pending flag, discard the word returned on the next imem_ready, and then issue a request to j_target.
REQ-025 SHALL, if flush and imem_ready arrive in the same cycle, discard imem_rdata and issue the next request to j_target.
REQ-026 SHALL give nWrite_IF_ID=1 priority over flush_IF_ID: IF/ID and PC are held and the redirect is ignored that cycle.
REQ-027 SHALL compute PC+4 modulo 2^32, so that 32'hFFFF_FFFC wraps to 0.
REQ-028 SHALL not check PC alignment: j_target is used as given.

Reset
REQ-029 SHALL, while rst_n=0, immediately set PC=RESET_PC, state=FETCH, inst_ID=0, pc4_ID=0, valid_ID=0, halted=0, imem_req=0, and clear the hold buffer and the redirect flag.
REQ-030 SHALL assert imem_req on the first clk edge after rst_n rises.
REQ-031 SHALL, on reset mid-request, drop the outstanding request; an imem_ready seen in the first cycle after reset is ignored.

Configuration
REQ-032 SHALL, with macro FETCH_HALT_EN defined, enter HALT when a word with opcode [31:26]=HALT_OP is delivered to IF/ID: no further requests, halted=1, IF/ID bubbles while nWrite_IF_ID=0.
REQ-033 SHALL, with FETCH_HALT_EN defined, leave HALT for FETCH at j_target and clear halted when flush_IF_ID=1 arrives in HALT (the halt word was on the wrong path); otherwise only reset exits HALT.
REQ-034 SHALL, without FETCH_HALT_EN, treat HALT_OP as an ordinary word, tie halted to 0 and omit the HALT state.

Verification
REQ-035 SHALL cover: zero-wait memory returning 0x20010005, 0x20020007 from address 0 -> inst_ID shows each on successive cycles, pc4_ID=4 then 8, valid_ID=1.
REQ-036 SHALL cover: imem_ready low for 2 cycles at PC=0x10 -> imem_addr holds 0x10, two bubbles, then the word with pc4_ID=0x14.
REQ-037 SHALL cover: nWrite_PC=nWrite_IF_ID=1 for 1 cycle while the word for 0x8 returns -> IF/ID holds the prior word, then delivers word@0x8 next cycle, with no refetch.
REQ-038 SHALL cover: flush_IF_ID=1 with j_target=0x40 while the 0x0C request is outstanding -> word@0x0C is discarded, a bubble is produced, and the next delivered pc4_ID is 0x44.
REQ-039 SHALL cover: flush_IF_ID and nWrite_IF_ID both 1 for 1 cycle, then flush only -> the first cycle is held, and the redirect takes effect on the second.
REQ-040 SHALL cover, with FETCH_HALT_EN: 0xFC000000 delivered -> halted=1 and imem_req=0 for 10 cycles; rst_n pulse -> imem_addr=RESET_PC and halted=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
// The master raises imem_req with a stable imem_addr; the slave answers with
// imem_ready and imem_rdata in the cycle the word is valid.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues requests on the fetch_unit_if bus, stalls through a one-entry hold
// buffer, and handles redirects that arrive while a request is in flight.
// Optional feature: define FETCH_HALT_EN to stop fetching when a word whose
// opcode [31:26] equals HALT_OP reaches IF/ID.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [5:0]  HALT_OP  = 6'b111111
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         nWrite_PC,
   input  logic         nWrite_IF_ID,
   input  logic         flush_IF_ID,
   input  logic [31:0]  j_target,
   fetch_unit_if.master imem,
   output logic [31:0]  inst_ID,
   output logic [31:0]  pc4_ID,
   output logic         valid_ID,
   output logic         halted
);

   // FETCH: request outstanding; HOLD: word buffered while IF/ID is stalled;
   // HALT: fetch stopped on a halt opcode.
   typedef enum logic [1:0] {
      FETCH,
      HOLD
`ifdef FETCH_HALT_EN
      ,
      HALT
`endif
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic [31:0] pc;
   logic [31:0] pc_nx;
   logic [31:0] pc_plus4;

   // Requests are enabled one edge after reset releases, so a stray
   // imem_ready in the first post-reset cycle is never accepted.
   logic        req_enable;

   logic [31:0] hold_buf;
   logic [31:0] hold_buf_nx;

   // A redirect that arrived while the current address was still being
   // fetched; the returning word is discarded and then redirect_pc is used.
   logic        redirect_pend;
   logic        redirect_pend_nx;
   logic [31:0] redirect_pc;
   logic [31:0] redirect_pc_nx;

   logic [31:0] inst_nx;
   logic [31:0] pc4_nx;
   logic        valid_nx;

   logic        deliver;
   logic [31:0] deliver_word;

   assign pc_plus4        = pc + 32'd4;
   assign imem.imem_addr  = pc;
   assign imem.imem_req   = req_enable && (state == FETCH);

`ifdef FETCH_HALT_EN
   assign halted = (state == HALT);
`else
   assign halted = 1'b0;
`endif

   // Next-state and next-register computation for the whole fetch stage.
   always_comb begin
      state_nx         = state;
      pc_nx            = pc;
      hold_buf_nx      = hold_buf;
      redirect_pend_nx = redirect_pend;
      redirect_pc_nx   = redirect_pc;
      inst_nx          = inst_ID;
      pc4_nx           = pc4_ID;
      valid_nx         = valid_ID;
      deliver          = 1'b0;
      deliver_word     = 32'd0;

      case (state)
         FETCH: begin
            if (req_enable) begin
               if (nWrite_IF_ID) begin
                  // IF/ID stalled: a stall beats any redirect this cycle.
                  if (imem.imem_ready) begin
                     if (redirect_pend) begin
                        pc_nx            = redirect_pc;
                        redirect_pend_nx = 1'b0;
                     end else begin
                        hold_buf_nx = imem.imem_rdata;
                        state_nx    = HOLD;
                     end
                  end
               end else if (flush_IF_ID) begin
                  inst_nx  = 32'd0;
                  valid_nx = 1'b0;
                  if (imem.imem_ready) begin
                     pc_nx            = j_target;
                     redirect_pend_nx = 1'b0;
                  end else begin
                     redirect_pend_nx = 1'b1;
                     redirect_pc_nx   = j_target;
                  end
               end else if (imem.imem_ready) begin
                  if (redirect_pend) begin
                     inst_nx          = 32'd0;
                     valid_nx         = 1'b0;
                     pc_nx            = redirect_pc;
                     redirect_pend_nx = 1'b0;
                  end else begin
                     deliver      = 1'b1;
                     deliver_word = imem.imem_rdata;
                  end
               end else begin
                  inst_nx  = 32'd0;
                  valid_nx = 1'b0;
               end
            end
         end

         HOLD: begin
            if (!nWrite_IF_ID) begin
               state_nx    = FETCH;
               hold_buf_nx = 32'd0;
               if (flush_IF_ID) begin
                  inst_nx  = 32'd0;
                  valid_nx = 1'b0;
                  pc_nx    = j_target;
               end else begin
                  deliver      = 1'b1;
                  deliver_word = hold_buf;
               end
            end
         end

`ifdef FETCH_HALT_EN
         HALT: begin
            if (!nWrite_IF_ID) begin
               inst_nx  = 32'd0;
               valid_nx = 1'b0;
               if (flush_IF_ID) begin
                  pc_nx    = j_target;
                  state_nx = FETCH;
               end
            end
         end
`endif

         default: begin
            state_nx = FETCH;
         end
      endcase

      if (deliver) begin
         inst_nx  = deliver_word;
         pc4_nx   = pc_plus4;
         valid_nx = 1'b1;
         if (!nWrite_PC) begin
            pc_nx = pc_plus4;
         end
`ifdef FETCH_HALT_EN
         if (deliver_word[31:26] == HALT_OP) begin
            state_nx = HALT;
         end
`endif
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_nx;
      end
   end

   // PC, IF/ID register, hold buffer and redirect bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_PC;
         req_enable    <= 1'b0;
         hold_buf      <= 32'd0;
         redirect_pend <= 1'b0;
         redirect_pc   <= 32'd0;
         inst_ID       <= 32'd0;
         pc4_ID        <= 32'd0;
         valid_ID      <= 1'b0;
      end else begin
         pc            <= pc_nx;
         req_enable    <= 1'b1;
         hold_buf      <= hold_buf_nx;
         redirect_pend <= redirect_pend_nx;
         redirect_pc   <= redirect_pc_nx;
         inst_ID       <= inst_nx;
         pc4_ID        <= pc4_nx;
         valid_ID      <= valid_nx;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        nWrite_PC;
   logic        nWrite_IF_ID;
   logic        flush_IF_ID;
   logic [31:0] j_target;
   logic [31:0] inst_ID;
   logic [31:0] pc4_ID;
   logic        valid_ID;
   logic        halted;

   int compared;
   int mismatched;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .HALT_OP  (6'b111111)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .nWrite_PC    (nWrite_PC),
      .nWrite_IF_ID (nWrite_IF_ID),
      .flush_IF_ID  (flush_IF_ID),
      .j_target     (j_target),
      .imem         (bus),
      .inst_ID      (inst_ID),
      .pc4_ID       (pc4_ID),
      .valid_ID     (valid_ID),
      .halted       (halted)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        nwpc;
      logic        nwif;
      logic        flush;
      logic [31:0] jt;
      logic        rdy;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc4;
      logic        exp_valid;
   } vec_t;

   vec_t vecs [24];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic driveInputs(input logic nwpc, input logic nwif, input logic flush,
                              input logic [31:0] jt, input logic rdy,
                              input logic [31:0] rdata);
      nWrite_PC       = nwpc;
      nWrite_IF_ID    = nwif;
      flush_IF_ID     = flush;
      j_target        = jt;
      bus.imem_ready  = rdy;
      bus.imem_rdata  = rdata;
   endtask

   // One cycle: drive at the falling edge, check bus outputs before the
   // rising edge, then check the IF/ID register just after it.
   task automatic applyStimulus(input int idx, input vec_t v);
      @(negedge clk);
      driveInputs(v.nwpc, v.nwif, v.flush, v.jt, v.rdy, v.rdata);
      #1;
      checkOutput($sformatf("v%0d imem_req", idx), {31'd0, bus.imem_req}, {31'd0, v.exp_req});
      checkOutput($sformatf("v%0d imem_addr", idx), bus.imem_addr, v.exp_addr);
      checkOutput($sformatf("v%0d halted_pre", idx), {31'd0, halted}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d inst_ID", idx), inst_ID, v.exp_inst);
      checkOutput($sformatf("v%0d pc4_ID", idx), pc4_ID, v.exp_pc4);
      checkOutput($sformatf("v%0d valid_ID", idx), {31'd0, valid_ID}, {31'd0, v.exp_valid});
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " imem_req"}, {31'd0, bus.imem_req}, 32'd0);
      checkOutput({tag, " imem_addr"}, bus.imem_addr, 32'h0000_0000);
      checkOutput({tag, " inst_ID"}, inst_ID, 32'd0);
      checkOutput({tag, " pc4_ID"}, pc4_ID, 32'd0);
      checkOutput({tag, " valid_ID"}, {31'd0, valid_ID}, 32'd0);
      checkOutput({tag, " halted"}, {31'd0, halted}, 32'd0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;

      //         nwpc  nwif  flush jt            rdy   rdata          req   addr           inst           pc4            valid
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2001_0005, 1'b1, 32'h0000_0000, 32'h2001_0005, 32'h0000_0004, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2002_0007, 1'b1, 32'h0000_0004, 32'h2002_0007, 32'h0000_0008, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hAAAA_0008, 1'b1, 32'h0000_0008, 32'h2002_0007, 32'h0000_0008, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1234_5678, 1'b0, 32'h0000_0008, 32'hAAAA_0008, 32'h0000_000C, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0,         32'h0000_000C, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hBBBB_000C, 1'b1, 32'h0000_000C, 32'h0,         32'h0000_000C, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hCCCC_0040, 1'b1, 32'h0000_0040, 32'hCCCC_0040, 32'h0000_0044, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h10,       1'b1, 32'hDDDD_0044, 1'b1, 32'h0000_0044, 32'h0,         32'h0000_0044, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0010, 32'h0,         32'h0000_0044, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0010, 32'h0,         32'h0000_0044, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1111_0010, 1'b1, 32'h0000_0010, 32'h1111_0010, 32'h0000_0014, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0,         1'b1, 32'h0000_0014, 32'h1111_0010, 32'h0000_0014, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h80,       1'b0, 32'h0,         1'b1, 32'h0000_0014, 32'h0,         32'h0000_0014, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hEEEE_0014, 1'b1, 32'h0000_0014, 32'h0,         32'h0000_0014, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2222_0080, 1'b1, 32'h0000_0080, 32'h2222_0080, 32'h0000_0084, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3333_0084, 1'b1, 32'h0000_0084, 32'h3333_0084, 32'h0000_0088, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4444_0084, 1'b1, 32'h0000_0084, 32'h4444_0084, 32'h0000_0088, 1'b1};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h5555_0088, 1'b1, 32'h0000_0088, 32'h4444_0084, 32'h0000_0088, 1'b1};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0000_0088, 32'h4444_0084, 32'h0000_0088, 1'b1};
      vecs[19] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC,1'b0, 32'h0,         1'b0, 32'h0000_0088, 32'h0,         32'h0000_0088, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h6666_0000, 1'b1, 32'hFFFF_FFFC, 32'h6666_0000, 32'h0000_0000, 1'b1};
      vecs[21] = '{1'b0, 1'b0, 1'b1, 32'h103,      1'b1, 32'h9999_0000, 1'b1, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h7777_0103, 1'b1, 32'h0000_0103, 32'h7777_0103, 32'h0000_0107, 1'b1};
      vecs[23] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFC00_0000, 1'b1, 32'h0000_0107, 32'hFC00_0000, 32'h0000_010B, 1'b1};

      // Reset state, then release with a stray ready that must be ignored.
      rst_n = 1'b0;
      driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkReset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h9999_9999);
      #1;
      checkOutput("post-reset req before edge", {31'd0, bus.imem_req}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("first edge imem_req", {31'd0, bus.imem_req}, 32'd1);
      checkOutput("first edge imem_addr", bus.imem_addr, 32'h0);
      checkOutput("stray ready valid_ID", {31'd0, valid_ID}, 32'd0);
      checkOutput("stray ready inst_ID", inst_ID, 32'd0);

      for (int i = 0; i < 24; i++) begin
         applyStimulus(i, vecs[i]);
      end

`ifdef FETCH_HALT_EN
      // Halt word delivered: no requests and bubbles for ten cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         #1;
         checkOutput($sformatf("halt%0d halted", i), {31'd0, halted}, 32'd1);
         checkOutput($sformatf("halt%0d imem_req", i), {31'd0, bus.imem_req}, 32'd0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("halt%0d valid_ID", i), {31'd0, valid_ID}, 32'd0);
      end
      // Reset pulse leaves HALT.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkReset("halt reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("halt reset imem_req", {31'd0, bus.imem_req}, 32'd1);
      // Halt again at address 0, then leave via flush.
      @(negedge clk);
      driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFC00_0000);
      @(posedge clk);
      #1;
      checkOutput("rehalt halted", {31'd0, halted}, 32'd1);
      checkOutput("rehalt inst_ID", inst_ID, 32'hFC00_0000);
      @(negedge clk);
      driveInputs(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("halt flush halted", {31'd0, halted}, 32'd0);
      checkOutput("halt flush valid_ID", {31'd0, valid_ID}, 32'd0);
      checkOutput("halt flush imem_req", {31'd0, bus.imem_req}, 32'd1);
      checkOutput("halt flush imem_addr", bus.imem_addr, 32'h200);
`else
      // Halt opcode is an ordinary word: fetch continues.
      @(negedge clk);
      driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("nohalt halted", {31'd0, halted}, 32'd0);
      checkOutput("nohalt imem_req", {31'd0, bus.imem_req}, 32'd1);
      checkOutput("nohalt imem_addr", bus.imem_addr, 32'h0000_010B);
`endif

      // Asynchronous reset in the middle of an outstanding request.
      @(negedge clk);
      driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      checkReset("mid reset");
      @(negedge clk);
      rst_n = 1'b1;
      driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      @(posedge clk);
      #1;
      checkOutput("mid reset stray valid_ID", {31'd0, valid_ID}, 32'd0);
      checkOutput("mid reset imem_req", {31'd0, bus.imem_req}, 32'd1);
      checkOutput("mid reset imem_addr", bus.imem_addr, 32'h0);
      @(negedge clk);
      driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1357_2468);
      @(posedge clk);
      #1;
      checkOutput("mid reset first inst_ID", inst_ID, 32'h1357_2468);
      checkOutput("mid reset first pc4_ID", pc4_ID, 32'h0000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
